// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM state encoding and parameter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

    localparam int APB_ADDR_W  = 8;
    localparam int APB_DATA_W  = 21;
    localparam int APB_TIMEOUT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_master.sv
// APB master: turns cmd_* requests into one APB transfer each, with a response pulse and a timeout abort.
// Latency: accept at cycle N -> SETUP N+1 -> ACCESS N+2.. -> rsp_valid one cycle after the last ACCESS cycle.
// Backpressure: cmd_ready only in IDLE or in the ACCESS cycle with PREADY; rsp has no ready and is a one-cycle pulse.
//
// Ports:
//   PCLK, PRESET                   clock, async-assert active-low reset (deassertion assumed already synchronised)
//   cmd_valid/ready/write/addr/wdata/wait   command side
//   rsp_valid/rdata/err            response side; rdata/err hold between pulses
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWAIT, PREADY, PRDATA   APB side
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_wait,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic [3:0]        PWAIT,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_t       state;
    apb_state_t       state_nxt;
    logic [CNT_W-1:0] tmo_cnt;
    logic             accept;
    logic             done;
    logic             expire;

    // Next-state and APB control decode. PREADY in the terminal ACCESS cycle
    // takes priority over the timeout, and an expiring transfer never raises
    // cmd_ready, so a timeout cannot chain straight into a new command.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        done      = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = SETUP;
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    done      = 1'b1;
                    cmd_ready = 1'b1;
                    state_nxt = cmd_valid ? SETUP : IDLE;
                end else if (tmo_cnt == CNT_LAST) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = cmd_valid & cmd_ready;

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state     <= IDLE;
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            PWAIT     <= '0;
            tmo_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;

            // Request fields only change on acceptance, so they stay stable
            // through SETUP and every ACCESS cycle of the transfer.
            if (accept) begin
                PADDR   <= cmd_addr;
                PWDATA  <= cmd_wdata;
                PWRITE  <= cmd_write;
                PWAIT   <= cmd_wait;
                tmo_cnt <= '0;
            end else if (state == ACCESS && !PREADY && !expire) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            rsp_valid <= done | expire;
            if (done) begin
                // PWRITE here is still the completing transfer's direction.
                rsp_rdata <= PWRITE ? '0 : PRDATA;
                rsp_err   <= 1'b0;
            end else if (expire) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [20:0] cmd_wdata;
    logic [3:0]  cmd_wait;
    logic        rsp_valid;
    logic [20:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [20:0] PWDATA;
    logic [3:0]  PWAIT;
    logic        PREADY;
    logic [20:0] PRDATA;

    int total = 0;
    int bad   = 0;

    apb_master #(.ADDR_W(8), .DATA_W(21), .TIMEOUT(32)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wait  (cmd_wait),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWAIT     (PWAIT),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave model: inserts PWAIT wait states, or never answers while stall is set.
    logic        stall = 1'b0;
    int unsigned acc_cnt = 0;
    logic [20:0] mem [256];

    assign PREADY = PSEL && PENABLE && !stall && (acc_cnt == 32'(PWAIT));
    assign PRDATA = mem[PADDR];

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command at the current negedge; returns at the SETUP-cycle negedge.
    task automatic issue(input logic w, input logic [7:0] a, input logic [20:0] d, input logic [3:0] wt);
        int k = 0;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wait  = wt;
        cmd_valid = 1'b1;
        while (!cmd_ready && k < 50) begin
            @(negedge PCLK);
            k++;
        end
        chk("accept_in_time", 32'(k < 50), 32'd1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    // From the SETUP negedge, count ACCESS cycles; returns at the negedge after ACCESS.
    task automatic run_access(output int n, output logic stable);
        logic [7:0] a0;
        a0     = PADDR;
        n      = 0;
        stable = 1'b1;
        @(negedge PCLK);
        while (PENABLE && n < 100) begin
            n++;
            if (PADDR !== a0 || PSEL !== 1'b1) stable = 1'b0;
            @(negedge PCLK);
        end
    endtask

    initial begin
        int   n;
        logic st;

        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wait  = '0;
        PRESET    = 1'b0;

        // Reset state
        @(negedge PCLK);
        chk("rst_psel",    32'(PSEL),      32'd0);
        chk("rst_penable", 32'(PENABLE),   32'd0);
        chk("rst_pwrite",  32'(PWRITE),    32'd0);
        chk("rst_paddr",   32'(PADDR),     32'd0);
        chk("rst_pwdata",  32'(PWDATA),    32'd0);
        chk("rst_pwait",   32'(PWAIT),     32'd0);
        chk("rst_rsp_vld", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err),   32'd0);
        chk("rst_rdata",   32'(rsp_rdata), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("rdy_after_rst", 32'(cmd_ready), 32'd1);

        // Zero-wait write: SETUP N+1, ACCESS N+2, rsp N+3
        issue(1'b1, 8'h10, 21'h1ABCD, 4'd0);
        chk("w1_setup_psel", 32'(PSEL),    32'd1);
        chk("w1_setup_pen",  32'(PENABLE), 32'd0);
        chk("w1_setup_rdy",  32'(cmd_ready), 32'd0);
        chk("w1_paddr",      32'(PADDR),   32'h10);
        chk("w1_pwdata",     32'(PWDATA),  32'h1ABCD);
        chk("w1_pwrite",     32'(PWRITE),  32'd1);
        @(negedge PCLK);
        chk("w1_acc_pen",    32'(PENABLE), 32'd1);
        chk("w1_acc_ready",  32'(PREADY),  32'd1);
        chk("w1_acc_rsp",    32'(rsp_valid), 32'd0);
        @(negedge PCLK);
        chk("w1_rsp_vld",    32'(rsp_valid), 32'd1);
        chk("w1_rsp_err",    32'(rsp_err),   32'd0);
        chk("w1_rsp_rdata",  32'(rsp_rdata), 32'd0);
        chk("w1_idle_psel",  32'(PSEL),      32'd0);
        @(negedge PCLK);
        chk("w1_rsp_pulse",  32'(rsp_valid), 32'd0);

        // Read with 3 wait states: 4 ACCESS cycles, PADDR stable
        issue(1'b0, 8'h10, 21'h0, 4'd3);
        chk("r1_pwait", 32'(PWAIT), 32'd3);
        run_access(n, st);
        chk("r1_acc_cycles", 32'(n),         32'd4);
        chk("r1_addr_stable", 32'(st),       32'd1);
        chk("r1_rsp_vld",    32'(rsp_valid), 32'd1);
        chk("r1_rsp_rdata",  32'(rsp_rdata), 32'h1ABCD);
        chk("r1_rsp_err",    32'(rsp_err),   32'd0);

        // Back-to-back: write 0x20 then read 0x10 with cmd_valid held
        @(negedge PCLK);
        cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 21'h00155; cmd_wait = 4'd0;
        cmd_valid = 1'b1;
        @(negedge PCLK);
        chk("b2b_a_setup",  32'(PSEL & ~PENABLE), 32'd1);
        chk("b2b_a_nordy",  32'(cmd_ready),       32'd0);
        cmd_write = 1'b0; cmd_addr = 8'h10; cmd_wdata = 21'h0;
        @(negedge PCLK);
        chk("b2b_a_access", 32'(PENABLE),   32'd1);
        chk("b2b_a_rdy",    32'(cmd_ready), 32'd1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        chk("b2b_b_setup",  32'(PSEL & ~PENABLE), 32'd1);
        chk("b2b_b_paddr",  32'(PADDR),     32'h10);
        chk("b2b_b_pwrite", 32'(PWRITE),    32'd0);
        chk("b2b_a_rsp",    32'(rsp_valid), 32'd1);
        @(negedge PCLK);
        chk("b2b_b_access", 32'(PENABLE),   32'd1);
        chk("b2b_gap",      32'(rsp_valid), 32'd0);
        @(negedge PCLK);
        chk("b2b_b_rsp",    32'(rsp_valid), 32'd1);
        chk("b2b_b_rdata",  32'(rsp_rdata), 32'h1ABCD);
        chk("b2b_idle",     32'(PSEL),      32'd0);
        @(negedge PCLK);
        chk("b2b_hold_vld",   32'(rsp_valid), 32'd0);
        chk("b2b_hold_rdata", 32'(rsp_rdata), 32'h1ABCD);
        chk("b2b_mem_a",      32'(mem[8'h20]), 32'h155);

        // Timeout: slave never ready
        stall = 1'b1;
        issue(1'b0, 8'h30, 21'h0, 4'd0);
        run_access(n, st);
        chk("to_acc_cycles", 32'(n),         32'd32);
        chk("to_rsp_vld",    32'(rsp_valid), 32'd1);
        chk("to_rsp_err",    32'(rsp_err),   32'd1);
        chk("to_rsp_rdata",  32'(rsp_rdata), 32'd0);
        chk("to_psel",       32'(PSEL),      32'd0);
        chk("to_idle_rdy",   32'(cmd_ready), 32'd1);
        @(negedge PCLK);
        chk("to_pulse",      32'(rsp_valid), 32'd0);
        chk("to_err_hold",   32'(rsp_err),   32'd1);
        stall = 1'b0;

        // Reset during ACCESS of a read
        issue(1'b0, 8'h10, 21'h0, 4'd5);
        @(negedge PCLK);
        chk("rr_in_access", 32'(PENABLE), 32'd1);
        #2 PRESET = 1'b0;
        #1;
        chk("rr_psel",    32'(PSEL),      32'd0);
        chk("rr_penable", 32'(PENABLE),   32'd0);
        chk("rr_paddr",   32'(PADDR),     32'd0);
        chk("rr_pwait",   32'(PWAIT),     32'd0);
        chk("rr_rsp_err", 32'(rsp_err),   32'd0);
        chk("rr_rsp_vld", 32'(rsp_valid), 32'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("rr_no_rsp",  32'(rsp_valid), 32'd0);
        chk("rr_rdy",     32'(cmd_ready), 32'd1);
        chk("rr_psel2",   32'(PSEL),      32'd0);

        // Write to 0xFF completes normally after reset
        issue(1'b1, 8'hFF, 21'h12345, 4'd0);
        run_access(n, st);
        chk("wff_acc_cycles", 32'(n),         32'd1);
        chk("wff_rsp_vld",    32'(rsp_valid), 32'd1);
        chk("wff_rsp_err",    32'(rsp_err),   32'd0);

        // Full-width data: write 0x1FFFFF to 0x00 then read back
        @(negedge PCLK);
        issue(1'b1, 8'h00, 21'h1FFFFF, 4'd2);
        run_access(n, st);
        chk("wfull_acc_cycles", 32'(n),         32'd3);
        chk("wfull_rsp_vld",    32'(rsp_valid), 32'd1);
        issue(1'b0, 8'h00, 21'h0, 4'd1);
        run_access(n, st);
        chk("rfull_acc_cycles", 32'(n),         32'd2);
        chk("rfull_rsp_vld",    32'(rsp_valid), 32'd1);
        chk("rfull_rdata",      32'(rsp_rdata), 32'h1FFFFF);
        issue(1'b0, 8'hFF, 21'h0, 4'd0);
        run_access(n, st);
        chk("rff_rdata",        32'(rsp_rdata), 32'h12345);

        repeat (2) @(negedge PCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 8, APB address width.
REQ-002 Parameter DATA_W, default 21, APB data width.
REQ-003 Parameter TIMEOUT, default 32, maximum ACCESS cycles before abort (range 2..255).
REQ-004 PCLK  input  1  clock; all state updates on rising edge.
REQ-005 PRESET  input  1  reset, asynchronous assert, active-low, synchronous deassert.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  target address.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 cmd_wait  input  4  wait-state count forwarded to slave.
REQ-012 rsp_valid  output  1  one-cycle response pulse.
REQ-013 rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-014 rsp_err  output  1  transfer aborted by timeout.
REQ-015 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-016 PADDR  output  ADDR_W;  PWDATA  output  DATA_W;  PWAIT  output  4  APB request fields.
REQ-017 PREADY  input  1;  PRDATA  input  DATA_W  APB slave response.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS; reset state IDLE.
REQ-019 cmd_ready = 1 only in IDLE, or in ACCESS during the cycle PREADY = 1 (back-to-back acceptance).
REQ-020 IDLE: on cmd_valid, register cmd_* into PADDR/PWDATA/PWRITE/PWAIT and go to SETUP; else stay, PSEL = 0.
REQ-021 SETUP: PSEL = 1, PENABLE = 0, exactly one cycle, then ACCESS.
REQ-022 ACCESS: PSEL = 1, PENABLE = 1; PADDR, PWRITE, PWDATA, PWAIT held stable until exit.
REQ-023 ACCESS with PREADY = 1: capture PRDATA (reads), pulse rsp_valid next cycle, rsp_err = 0; go to SETUP if cmd_valid (new command registered), else IDLE.
REQ-024 Timeout counter cleared on SETUP entry, incremented each ACCESS cycle with PREADY = 0; when it reaches TIMEOUT-1 with PREADY still 0, drop PSEL/PENABLE, pulse rsp_valid with rsp_err = 1, rsp_rdata = 0, go to IDLE.
REQ-025 Timeout never accepts a new command in the same cycle; PREADY = 1 in the terminal cycle wins over timeout.
REQ-026 Minimum transfer latency: command accepted at cycle N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid N+3 with zero wait.
REQ-027 rsp_rdata/rsp_err hold last values between pulses; rsp_valid high exactly one cycle per accepted command.
REQ-028 PWDATA is don't-care for reads but driven with registered cmd_wdata; PRDATA ignored on writes.

Reset
REQ-029 Reset mid-transfer aborts immediately: FSM IDLE, no response issued for the aborted command.
REQ-030 Reset values: PSEL, PENABLE, PWRITE, rsp_valid, rsp_err = 0; PADDR, PWDATA, PWAIT, rsp_rdata, timeout counter = 0; cmd_ready = 1 once reset deasserts.

Structure
REQ-031 Shared package apb_pkg holds state enum (IDLE, SETUP, ACCESS), ADDR_W/DATA_W defaults and TIMEOUT default.
REQ-032 Single module; no sub-module; timeout counter inline, width $clog2(TIMEOUT).
REQ-033 Integrates upstream of the existing APB slave/memory wrapper, port-to-port on PCLK, PRESET, PSEL, PENABLE, PADDR, PWRITE, PWDATA, PWAIT, PREADY, PRDATA.

Verification
REQ-034 Write addr 0x10 data 0x1ABCD, cmd_wait 0, slave ready immediately -> SETUP/ACCESS each one cycle, rsp_valid at N+3, rsp_err 0.
REQ-035 Read back 0x10 with cmd_wait 3 -> ACCESS lasts 4 cycles, PADDR stable, rsp_rdata 0x1ABCD.
REQ-036 Two commands back-to-back (cmd_valid held) -> second SETUP directly follows first ACCESS completion, no IDLE cycle, two rsp_valid pulses.
REQ-037 PREADY tied 0, TIMEOUT 32 -> PSEL drops after 32 ACCESS cycles, rsp_err 1, rsp_rdata 0, FSM IDLE.
REQ-038 PRESET asserted during ACCESS of a read -> outputs at reset values asynchronously, no rsp_valid; following write to 0xFF completes normally.
REQ-039 Write 0x1FFFFF to 0x00 then read -> full 21-bit value returned, no truncation.
